// File: rtl/bus_drvr_fifo.sv
// Per-terminal bus endpoint: a TX queue feeding the arbiter's pndng/D_pop port and
// an address-filtered RX queue fed by the arbiter's push/D_push port.

module bus_drvr_fifo_q #(
  parameter int W     = 16,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr,
  input  logic [W-1:0]             wr_data,
  input  logic                     rd,
  output logic [W-1:0]             head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     drop
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr, rd_ptr_nxt;
  logic [CW-1:0] remain, count_nxt;
  logic [W-1:0]  head_nxt;
  logic          do_rd, do_wr;

  // A read on a full queue frees the slot the same-edge write lands in.
  always_comb begin
    do_rd      = rd && (count != '0);
    do_wr      = wr && ((count != CW'(DEPTH)) || do_rd);
    drop       = wr && !do_wr;
    rd_ptr_nxt = do_rd ? rd_ptr + AW'(1) : rd_ptr;
    remain     = count - CW'(do_rd);
    count_nxt  = remain + CW'(do_wr);
    head_nxt   = '0;
    // Show-ahead head: the surviving oldest entry, or the incoming word if none survives.
    if (remain != '0)
      head_nxt = mem[rd_ptr_nxt];
    else if (do_wr)
      head_nxt = wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      head   <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      rd_ptr <= rd_ptr_nxt;
      count  <= count_nxt;
      head   <= head_nxt;
    end
  end

  // NOTE: storage has no reset; occupancy gates every read, so stale contents are never visible.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end
endmodule

module bus_drvr_fifo #(
  parameter int          pckg_sz   = 16,
  parameter int          depth     = 8,
  parameter logic [7:0]  ID        = 8'd0,
  parameter logic [7:0]  broadcast = 8'hFF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     tx_wr,
  input  logic [pckg_sz-1:0]       tx_data,
  output logic                     tx_full,
  output logic [$clog2(depth):0]   tx_count,
  output logic                     pndng,
  output logic [pckg_sz-1:0]       D_pop,
  input  logic                     pop,
  input  logic                     push,
  input  logic [pckg_sz-1:0]       D_push,
  input  logic                     rx_rd,
  output logic [pckg_sz-1:0]       rx_data,
  output logic                     rx_vld,
  output logic                     rx_full,
  output logic [7:0]               tx_drop_cnt,
  output logic [7:0]               rx_drop_cnt,
  output logic [7:0]               misroute_cnt
);
  localparam int CW = $clog2(depth) + 1;

  logic [CW-1:0] rx_count;
  logic [7:0]    dest;
  logic          rx_hit, misroute, tx_drop, rx_drop;

  assign dest     = D_push[pckg_sz-1 -: 8];
  assign rx_hit   = push && ((dest == ID) || (dest == broadcast));
  assign misroute = push && !rx_hit;

  bus_drvr_fifo_q #(.W(pckg_sz), .DEPTH(depth)) u_tx (
    .clk     (clk),
    .rst_n   (reset),
    .wr      (tx_wr),
    .wr_data (tx_data),
    .rd      (pop),
    .head    (D_pop),
    .count   (tx_count),
    .drop    (tx_drop)
  );

  bus_drvr_fifo_q #(.W(pckg_sz), .DEPTH(depth)) u_rx (
    .clk     (clk),
    .rst_n   (reset),
    .wr      (rx_hit),
    .wr_data (D_push),
    .rd      (rx_rd),
    .head    (rx_data),
    .count   (rx_count),
    .drop    (rx_drop)
  );

  // Flags come straight from registered occupancy, never from pop/rx_rd.
  assign pndng   = (tx_count != '0);
  assign tx_full = (tx_count == CW'(depth));
  assign rx_vld  = (rx_count != '0);
  assign rx_full = (rx_count == CW'(depth));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_drop_cnt  <= '0;
      rx_drop_cnt  <= '0;
      misroute_cnt <= '0;
    end else begin
      if (tx_drop  && tx_drop_cnt  != 8'hFF) tx_drop_cnt  <= tx_drop_cnt  + 8'd1;
      if (rx_drop  && rx_drop_cnt  != 8'hFF) rx_drop_cnt  <= rx_drop_cnt  + 8'd1;
      if (misroute && misroute_cnt != 8'hFF) misroute_cnt <= misroute_cnt + 8'd1;
    end
  end
endmodule

// File: tb/tb_bus_drvr_fifo.sv
// Directed bench for bus_drvr_fifo (ID=3, depth=8): TX queue, RX filtering, overflow,
// counter saturation and asynchronous reset.

module tb_bus_drvr_fifo;
  logic        clk = 1'b0;
  logic        reset;
  logic        tx_wr, pop, push, rx_rd;
  logic [15:0] tx_data, D_push;
  logic        tx_full, pndng, rx_vld, rx_full;
  logic [3:0]  tx_count;
  logic [15:0] D_pop, rx_data;
  logic [7:0]  tx_drop_cnt, rx_drop_cnt, misroute_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bus_drvr_fifo #(.pckg_sz(16), .depth(8), .ID(8'd3), .broadcast(8'hFF)) dut (
    .clk          (clk),
    .reset        (reset),
    .tx_wr        (tx_wr),
    .tx_data      (tx_data),
    .tx_full      (tx_full),
    .tx_count     (tx_count),
    .pndng        (pndng),
    .D_pop        (D_pop),
    .pop          (pop),
    .push         (push),
    .D_push       (D_push),
    .rx_rd        (rx_rd),
    .rx_data      (rx_data),
    .rx_vld       (rx_vld),
    .rx_full      (rx_full),
    .tx_drop_cnt  (tx_drop_cnt),
    .rx_drop_cnt  (rx_drop_cnt),
    .misroute_cnt (misroute_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; tx_wr = 1'b0; pop = 1'b0; push = 1'b0; rx_rd = 1'b0;
    tx_data = '0; D_push = '0;
    repeat (3) tick();
    check("rst_pndng",   32'(pndng), 32'd0);
    check("rst_d_pop",   32'(D_pop), 32'd0);
    check("rst_rx_vld",  32'(rx_vld), 32'd0);
    check("rst_rx_data", 32'(rx_data), 32'd0);
    check("rst_tx_full", 32'(tx_full), 32'd0);
    check("rst_rx_full", 32'(rx_full), 32'd0);
    check("rst_tx_cnt",  32'(tx_count), 32'd0);
    @(negedge clk); reset = 1'b1;
    tick();

    // Single packet in and out.
    tx_wr = 1'b1; tx_data = 16'h02AB; tick(); tx_wr = 1'b0;
    check("wr1_pndng", 32'(pndng), 32'd1);
    check("wr1_d_pop", 32'(D_pop), 32'h02AB);
    check("wr1_count", 32'(tx_count), 32'd1);
    pop = 1'b1; tick(); pop = 1'b0;
    check("pop1_pndng", 32'(pndng), 32'd0);
    check("pop1_d_pop", 32'(D_pop), 32'd0);
    pop = 1'b1; tick(); pop = 1'b0;
    check("pop_empty_count", 32'(tx_count), 32'd0);

    // Nine writes into eight slots.
    for (int i = 0; i < 9; i++) begin
      tx_wr = 1'b1; tx_data = 16'h1000 + 16'(i); tick();
      if (i == 7) check("fill_full", 32'(tx_full), 32'd1);
    end
    tx_wr = 1'b0;
    check("ovf_drop",  32'(tx_drop_cnt), 32'd1);
    check("ovf_count", 32'(tx_count), 32'd8);
    check("ovf_head",  32'(D_pop), 32'h1000);

    // Write and pop together while full.
    tx_wr = 1'b1; tx_data = 16'hBEEF; pop = 1'b1; tick(); tx_wr = 1'b0; pop = 1'b0;
    check("wp_full_count", 32'(tx_count), 32'd8);
    check("wp_full_drop",  32'(tx_drop_cnt), 32'd1);
    for (int i = 1; i < 9; i++) begin
      check($sformatf("drain_%0d", i), 32'(D_pop), (i == 8) ? 32'hBEEF : 32'h1000 + 32'(i));
      pop = 1'b1; tick(); pop = 1'b0;
    end
    check("drain_pndng", 32'(pndng), 32'd0);

    // Write and pop together while empty, then with one entry.
    tx_wr = 1'b1; tx_data = 16'h0A0A; pop = 1'b1; tick();
    check("wp_empty_count", 32'(tx_count), 32'd1);
    check("wp_empty_head",  32'(D_pop), 32'h0A0A);
    tx_data = 16'h0B0B; tick(); tx_wr = 1'b0;
    check("wp_one_count", 32'(tx_count), 32'd1);
    check("wp_one_head",  32'(D_pop), 32'h0B0B);
    tick(); pop = 1'b0;
    check("wp_end_pndng", 32'(pndng), 32'd0);

    // Destination filtering.
    push = 1'b1; D_push = 16'h0311; tick();
    check("rx1_vld",  32'(rx_vld), 32'd1);
    check("rx1_data", 32'(rx_data), 32'h0311);
    D_push = 16'hFF22; tick();
    D_push = 16'h0533; tick(); push = 1'b0;
    check("rx_misroute", 32'(misroute_cnt), 32'd1);
    check("rx_nodrop",   32'(rx_drop_cnt), 32'd0);
    rx_rd = 1'b1; tick();
    check("rx2_data", 32'(rx_data), 32'hFF22);
    tick();
    check("rx_empty_vld",  32'(rx_vld), 32'd0);
    check("rx_empty_data", 32'(rx_data), 32'd0);
    tick(); rx_rd = 1'b0;
    check("rx_rd_empty_vld", 32'(rx_vld), 32'd0);

    // RX overflow, then push with a same-cycle read.
    for (int i = 0; i < 8; i++) begin
      push = 1'b1; D_push = 16'h0300 + 16'(i); tick();
    end
    check("rx_fill_full", 32'(rx_full), 32'd1);
    D_push = 16'h03EE; tick();
    check("rx_ovf_drop", 32'(rx_drop_cnt), 32'd1);
    D_push = 16'h03FF; rx_rd = 1'b1; tick(); push = 1'b0; rx_rd = 1'b0;
    check("rx_rp_full", 32'(rx_full), 32'd1);
    check("rx_rp_drop", 32'(rx_drop_cnt), 32'd1);
    for (int i = 1; i < 9; i++) begin
      check($sformatf("rx_drain_%0d", i), 32'(rx_data), (i == 8) ? 32'h03FF : 32'h0300 + 32'(i));
      rx_rd = 1'b1; tick(); rx_rd = 1'b0;
    end
    check("rx_drain_vld", 32'(rx_vld), 32'd0);

    // Saturate tx_drop_cnt (one drop so far plus 260 more).
    tx_wr = 1'b1;
    for (int i = 0; i < 268; i++) begin
      tx_data = 16'h2000 + 16'(i); tick();
    end
    tx_wr = 1'b0;
    check("sat_tx_drop", 32'(tx_drop_cnt), 32'd255);
    check("sat_head",    32'(D_pop), 32'h2000);

    // Asynchronous reset between edges with both queues occupied.
    push = 1'b1; D_push = 16'h03AA; tick(); push = 1'b0;
    check("pre_rst_vld", 32'(rx_vld), 32'd1);
    #3 reset = 1'b0;
    #1;
    check("arst_pndng",    32'(pndng), 32'd0);
    check("arst_d_pop",    32'(D_pop), 32'd0);
    check("arst_tx_count", 32'(tx_count), 32'd0);
    check("arst_rx_vld",   32'(rx_vld), 32'd0);
    check("arst_tx_drop",  32'(tx_drop_cnt), 32'd0);
    check("arst_rx_drop",  32'(rx_drop_cnt), 32'd0);
    check("arst_misroute", 32'(misroute_cnt), 32'd0);
    @(negedge clk); reset = 1'b1;
    tx_wr = 1'b1; tx_data = 16'h0CDE; tick(); tx_wr = 1'b0;
    check("post_rst_count", 32'(tx_count), 32'd1);
    check("post_rst_head",  32'(D_pop), 32'h0CDE);
    check("post_rst_pndng", 32'(pndng), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/bus_drvr_fifo.md
Name: bus_drvr_fifo

Overview:
- Per-terminal endpoint that sits between one device and one port of the bus generator/arbiter (bs_gnrtr_n_rbtr).
- TX side: buffers device packets, presents them to the bus through pndng/D_pop, and consumes them on the arbiter's pop.
- RX side: captures packets the arbiter delivers via push/D_push, filters them by destination, and queues them for the device.
- One instance per driver; the top level instantiates drvrs copies with distinct ID.

Parameters:
- pckg_sz, 16, packet width in bits. Bits [pckg_sz-1:pckg_sz-8] are the destination ID; the remaining low bits are payload.
- depth, 8, entries per FIFO (TX and RX each). Must be a power of 2, at least 2.
- ID, 0, this terminal's 8-bit address.
- broadcast, 8'hFF, destination value that every terminal accepts.

Ports:
- clk  in  1  single clock; all state is updated on the rising edge.
- reset  in  1  asynchronous, active-low reset; 0 clears all state.
- tx_wr  in  1  device write strobe.
- tx_data  in  pckg_sz  packet to send.
- tx_full  out  1  TX FIFO holds depth entries.
- tx_count  out  $clog2(depth)+1  TX occupancy.
- pndng  out  1  TX FIFO not empty; drives the arbiter's pndng.
- D_pop  out  pckg_sz  TX head entry; drives the arbiter's D_pop.
- pop  in  1  arbiter consumed the head entry.
- push  in  1  arbiter delivers a packet.
- D_push  in  pckg_sz  delivered packet.
- rx_rd  in  1  device read strobe.
- rx_data  out  pckg_sz  RX head entry.
- rx_vld  out  1  RX FIFO not empty.
- rx_full  out  1  RX FIFO holds depth entries.
- tx_drop_cnt  out  8  TX writes discarded because the FIFO was full.
- rx_drop_cnt  out  8  RX packets discarded because the FIFO was full.
- misroute_cnt  out  8  pushes whose destination was neither ID nor broadcast.

Behaviour:
- Reset (reset=0, asynchronous):
  - all pointers, occupancies and counters go to 0;
  - pndng=0, rx_vld=0, tx_full=0, rx_full=0;
  - D_pop and rx_data = 0.
  - Reset asserted mid-operation discards all queued packets immediately.
- FIFOs are show-ahead:
  - D_pop and rx_data are registered copies of the head entry.
  - Each is valid in the same cycle its flag (pndng / rx_vld) is 1.
  - Each reads 0 when its FIFO is empty.
- TX write:
  - tx_wr=1 with tx_full=0 stores tx_data at the tail.
  - Write into an empty FIFO at edge N: pndng=1 and D_pop=tx_data after edge N. Latency is 1 cycle.
- TX pop:
  - pop=1 with pndng=1 advances the head; D_pop shows the next entry after the edge.
  - pop=1 with pndng=0 is ignored; no state change.
- Simultaneous TX write and pop:
  - Both take effect and tx_count is unchanged.
  - If the FIFO is full, the write is accepted because the pop frees a slot in the same edge.
  - If the FIFO is empty, only the write takes effect (the pop is ignored).
- TX write while full (no pop): data discarded; tx_drop_cnt increments.
- RX accept: on push=1, dest = D_push[pckg_sz-1:pckg_sz-8].
  - If dest==ID or dest==broadcast, the packet is enqueued, subject to space.
  - Otherwise the packet is discarded and misroute_cnt increments.
- RX full:
  - An accepted push with rx_full=1 and rx_rd=0 is discarded; rx_drop_cnt increments.
  - An accepted push with rx_full=1 and rx_rd=1 is stored; the read frees the slot in the same edge.
- RX read:
  - rx_rd=1 with rx_vld=1 advances the head.
  - rx_rd=1 with rx_vld=0 is ignored.
  - A push into an empty FIFO gives rx_vld=1 one cycle later.
- Counters:
  - All three saturate at 255, with no wrap.
  - They clear only on reset.
- Pointers:
  - Width $clog2(depth); they wrap modulo depth.
  - Full/empty are derived from the occupancy counter, so there is no pointer-equality ambiguity.
- pndng must not depend combinationally on pop. The arbiter samples it registered.

Test Plan:
- Reset, then tx_wr with 16'h02AB -> next cycle pndng=1, D_pop=16'h02AB, tx_count=1. Then pop for one cycle -> pndng=0, D_pop=0.
- With depth=8, write 9 packets back-to-back and no pops -> tx_full=1 after the 8th, 9th packet dropped, tx_drop_cnt=1. Then 8 pops -> FIFO order preserved, pointers wrap correctly.
- With the TX FIFO full, assert tx_wr and pop in the same cycle -> tx_count stays 8, tx_drop_cnt unchanged, new packet emerges last.
- ID=3 receives pushes of 16'h0311, 16'hFF22 and 16'h0533 -> first two queued in order with rx_vld=1; third discarded, misroute_cnt=1.
- Fill RX to 8 entries, then one push with rx_rd=0 -> rx_drop_cnt=1. Then a push with rx_rd=1 in the same cycle -> stored, rx_full stays 1.
- Drive reset=0 asynchronously, between clock edges, while both FIFOs hold data -> pndng, rx_vld and all counters read 0 immediately. After release, the first write behaves as from empty.
